// File: rtl/ibuf_access_ctrl_if.sv
// Read-data stream from ibuf_access_ctrl to the main process.
// Valid/ready handshake; a beat transfers when O_rvalid & I_rready.
interface ibuf_access_ctrl_if #(
   parameter int DSIZE = 32
);
   logic [DSIZE-1:0] O_rdata;
   logic             O_rvalid;
   logic             O_rlast;
   logic             I_rready;

   modport master (
      output O_rdata, O_rvalid, O_rlast,
      input  I_rready
   );
   modport slave (
      input  O_rdata, O_rvalid, O_rlast,
      output I_rready
   );
endinterface

// File: rtl/ibuf_access_ctrl.sv
// Single-port spram arbiter: packed write stream plus burst reads
// returned through a 4-entry credit-controlled output FIFO.
module ibuf_access_ctrl #(
   parameter int ASIZE = 10,
   parameter int DSIZE = 32
) (
   input  logic               I_clk,
   input  logic               I_rst,
   input  logic               I_wclr,
   input  logic [DSIZE-1:0]   I_wdata,
   input  logic               I_wvalid,
   output logic               O_wready,
   output logic [ASIZE:0]     O_wcnt,
   input  logic               I_rd_start,
   input  logic [ASIZE-1:0]   I_rd_base,
   input  logic [ASIZE:0]     I_rd_len,
   output logic               O_rd_busy,
   output logic               O_rd_done,
   ibuf_access_ctrl_if.master rd_if,
   output logic [ASIZE-1:0]   O_ram_addr,
   output logic [DSIZE-1:0]   O_ram_data,
   output logic               O_ram_ce,
   output logic               O_ram_wr,
   input  logic [DSIZE-1:0]   I_ram_data
);
   localparam int DEPTH = 1 << ASIZE;
   localparam logic [ASIZE:0] C_DEPTH = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] C_ONE   = (ASIZE+1)'(1);

   typedef enum logic [1:0] {IDLE, RD, DRAIN, DONE} state_t;

   state_t           r_state;
   logic [ASIZE-1:0] r_base;
   logic [ASIZE-1:0] r_wptr;
   logic [ASIZE:0]   r_len;
   logic [ASIZE:0]   r_idx;
   logic [ASIZE:0]   r_wcnt;
   logic             r_inflight;
   logic             r_infl_last;
   logic [DSIZE-1:0] r_fdata [4];
   logic [3:0]       r_flast;
   logic [1:0]       r_fwp;
   logic [1:0]       r_frp;
   logic [2:0]       r_fcnt;

   logic             w_issue;
   logic             w_last_issue;
   logic             w_wacc;
   logic             w_push;
   logic             w_pop;
   logic             w_rvalid;
   logic             w_head_last;
   logic [ASIZE-1:0] w_rd_addr;
   logic [ASIZE-1:0] w_wr_addr;

   // Credit check uses only registered terms, never I_rready.
   assign w_issue      = ~I_rst & (r_state == RD) &
                         ((r_fcnt + {2'b0, r_inflight}) < 3'd4);
   assign w_last_issue = w_issue & (r_idx == r_len - C_ONE);
   assign w_rd_addr    = r_base + r_idx[ASIZE-1:0];
   assign w_wr_addr    = I_wclr ? '0 : r_wptr;

   assign O_wready = ~I_rst & ~w_issue;
   assign w_wacc   = I_wvalid & O_wready;

   assign O_ram_ce   = w_issue | w_wacc;
   assign O_ram_wr   = w_wacc;
   assign O_ram_addr = w_issue ? w_rd_addr :
                       (w_wacc ? w_wr_addr : '0);
   assign O_ram_data = w_wacc ? I_wdata : '0;

   assign O_wcnt    = I_rst ? '0 : r_wcnt;
   assign O_rd_busy = ~I_rst & ((r_state == RD) | (r_state == DRAIN));
   assign O_rd_done = ~I_rst & (r_state == DONE);

   assign w_rvalid    = ~I_rst & (r_fcnt != 3'd0);
   assign w_head_last = r_flast[r_frp];
   assign w_pop       = w_rvalid & rd_if.I_rready;
   assign w_push      = r_inflight;

   assign rd_if.O_rvalid = w_rvalid;
   assign rd_if.O_rdata  = w_rvalid ? r_fdata[r_frp] : '0;
   assign rd_if.O_rlast  = w_rvalid & w_head_last;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_state     <= IDLE;
         r_base      <= '0;
         r_len       <= '0;
         r_idx       <= '0;
         r_inflight  <= 1'b0;
         r_infl_last <= 1'b0;
      end else begin
         r_inflight  <= w_issue;
         r_infl_last <= w_last_issue;
         if (w_issue)
            r_idx <= r_idx + C_ONE;
         unique case (r_state)
            IDLE: if (I_rd_start) begin
               r_base  <= I_rd_base;
               r_len   <= I_rd_len;
               r_idx   <= '0;
               r_state <= (I_rd_len == '0) ? DONE : RD;
            end
            RD:      if (w_last_issue) r_state <= DRAIN;
            DRAIN:   if (w_pop & w_head_last) r_state <= DONE;
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // A clear that coincides with an accept places that word at 0.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_wptr <= '0;
         r_wcnt <= '0;
      end else if (I_wclr) begin
         r_wptr <= ASIZE'(w_wacc);
         r_wcnt <= (ASIZE+1)'(w_wacc);
      end else if (w_wacc) begin
         r_wptr <= r_wptr + ASIZE'(1);
         if (r_wcnt != C_DEPTH)
            r_wcnt <= r_wcnt + C_ONE;
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_fwp   <= '0;
         r_frp   <= '0;
         r_fcnt  <= '0;
         r_flast <= '0;
      end else begin
         if (w_push) begin
            r_flast[r_fwp] <= r_infl_last;
            r_fwp          <= r_fwp + 2'd1;
         end
         if (w_pop)
            r_frp <= r_frp + 2'd1;
         r_fcnt <= r_fcnt + {2'b0, w_push} - {2'b0, w_pop};
      end
   end

   always_ff @(posedge I_clk) begin
      if (w_push)
         r_fdata[r_fwp] <= I_ram_data;
   end
endmodule

// File: tb/tb_ibuf_access_ctrl.sv
// Bench for ibuf_access_ctrl: spram model, abstract scoreboard
// checked every cycle, plus literal expectations per scenario.
module tb_ibuf_access_ctrl;
   localparam int AS  = 4;
   localparam int DS  = 32;
   localparam int DEP = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wclr = 1'b0;
   logic          wvalid = 1'b0;
   logic          rd_start = 1'b0;
   logic [DS-1:0] wdata = '0;
   logic [AS-1:0] rd_base = '0;
   logic [AS:0]   rd_len = '0;
   logic          wready, busy, done, ce, wr;
   logic [AS:0]   wcnt;
   logic [AS-1:0] addr;
   logic [DS-1:0] ram_d;
   logic [DS-1:0] ram_q = '0;
   logic [DS-1:0] ram [DEP];

   int vec = 0;
   int mis = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   ibuf_access_ctrl_if #(.DSIZE(DS)) rif ();

   ibuf_access_ctrl #(.ASIZE(AS), .DSIZE(DS)) dut (
      .I_clk(clk), .I_rst(rst), .I_wclr(wclr),
      .I_wdata(wdata), .I_wvalid(wvalid), .O_wready(wready),
      .O_wcnt(wcnt), .I_rd_start(rd_start), .I_rd_base(rd_base),
      .I_rd_len(rd_len), .O_rd_busy(busy), .O_rd_done(done),
      .rd_if(rif.master), .O_ram_addr(addr), .O_ram_data(ram_d),
      .O_ram_ce(ce), .O_ram_wr(wr), .I_ram_data(ram_q)
   );

   always @(posedge clk) begin
      if (ce) begin
         if (wr) ram[addr] <= ram_d;
         else    ram_q <= ram[addr];
      end
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: phase 0 idle, 1 burst active, 2 done pulse.
   typedef struct { logic [DS-1:0] d; logic l; int t; } beat_t;
   logic [DS-1:0] shadow [DEP];
   int    aq[$];
   beat_t dq[$];
   int    m_wptr = 0, m_wcnt = 0, m_phase = 0, m_out = 0;

   always @(negedge clk) begin
      int    nph, a;
      bit    iss, exp_iss, acc, exp_rv;
      beat_t b;
      if (rst) begin
         chk("rst_outs", {wready, busy, done, ce, wr, rif.O_rvalid,
             rif.O_rlast, wcnt, addr, rif.O_rdata}, '0);
         m_wptr = 0; m_wcnt = 0; m_phase = 0; m_out = 0;
         aq.delete(); dq.delete();
      end else begin
         nph     = (m_phase == 2) ? 0 : m_phase;
         iss     = ce && !wr;
         exp_iss = (m_phase == 1) && (aq.size() > 0) && (m_out < 4);
         acc     = wvalid && !exp_iss;
         chk("issue", iss, exp_iss);
         chk("wready", wready, !exp_iss);
         chk("wr_strobe", ce && wr, acc);
         chk("wcnt", wcnt, m_wcnt);
         chk("busy", busy, m_phase == 1);
         chk("done", done, m_phase == 2);
         if (acc) begin
            chk("waddr", addr, wclr ? 0 : m_wptr);
            chk("wdata_ram", ram_d, wdata);
         end
         if (iss && exp_iss) begin
            a = aq.pop_front();
            chk("raddr", addr, a);
            b.d = shadow[a]; b.l = (aq.size() == 0); b.t = cyc;
            dq.push_back(b);
            m_out++;
         end
         if (acc) shadow[wclr ? 0 : m_wptr] = wdata;
         if (wclr) begin
            m_wptr = acc ? 1 : 0; m_wcnt = acc ? 1 : 0;
         end else if (acc) begin
            m_wptr = (m_wptr + 1) % DEP;
            if (m_wcnt < DEP) m_wcnt++;
         end
         exp_rv = (dq.size() > 0) && (cyc >= dq[0].t + 2);
         chk("rvalid", rif.O_rvalid, exp_rv);
         if (exp_rv) begin
            chk("rdata", rif.O_rdata, dq[0].d);
            chk("rlast", rif.O_rlast, dq[0].l);
            if (rif.I_rready) begin
               if (dq[0].l) nph = 2;
               void'(dq.pop_front());
               m_out--;
            end
         end
         if (rd_start && m_phase == 0) begin
            if (rd_len == 0) nph = 2;
            else begin
               nph = 1;
               for (int i = 0; i < int'(rd_len); i++)
                  aq.push_back((int'(rd_base) + i) % DEP);
            end
         end
         m_phase = nph;
      end
      cyc++;
   end

   task automatic nx();
      @(posedge clk); #1;
   endtask

   task automatic wait_done(string nm, bit rnd);
      int k = 0;
      while (!done && k < 300) begin
         if (rnd) rif.I_rready = 1'($urandom_range(0, 1));
         nx(); k++;
      end
      chk(nm, done, 1'b1);
      rif.I_rready = 1'b1;
      nx();
   endtask

   task automatic start(int base, int len);
      rd_base = AS'(base); rd_len = (AS+1)'(len); rd_start = 1'b1;
      nx();
      rd_start = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEP; i++) begin
         ram[i] = '0; shadow[i] = '0;
      end
      rif.I_rready = 1'b1;
      repeat (3) nx();
      rst = 1'b0;

      // plain packed write stream
      wclr = 1'b1; nx(); wclr = 1'b0;
      wvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wdata = 32'hA0 + 32'(i);
         @(negedge clk);
         chk("t1_addr", addr, i); chk("t1_wready", wready, 1'b1);
         nx();
      end
      wvalid = 1'b0;
      @(negedge clk); chk("t1_wcnt", wcnt, 8); nx();

      // latency and beat order of a short burst
      start(2, 4);
      @(negedge clk); chk("t2_lat0", rif.O_rvalid, 0); chk("t2_a0", addr, 2); nx();
      @(negedge clk); chk("t2_lat1", rif.O_rvalid, 0); nx();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_data", rif.O_rdata, 32'hA2 + 32'(i));
         chk("t2_last", rif.O_rlast, i == 3);
         nx();
      end
      @(negedge clk); chk("t2_done", done, 1); chk("t2_busy", busy, 0); nx();
      @(negedge clk); chk("t2_done_off", done, 0); nx();

      // read address wrap
      start(14, 4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("t3_addr", addr, (14 + i) % DEP); nx();
      end
      wait_done("t3_done", 0);

      // write pointer wrap and count saturation
      wclr = 1'b1; nx(); wclr = 1'b0;
      wvalid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wdata = 32'hB0 + 32'(i); nx();
      end
      wvalid = 1'b0;
      @(negedge clk); chk("t3_wsat", wcnt, 16); nx();
      wvalid = 1'b1; wdata = 32'hBEEF;
      @(negedge clk); chk("t3_wwrap", addr, 1); nx();
      wvalid = 1'b0;
      @(negedge clk); chk("t3_wsat2", wcnt, 16); nx();

      // full-depth burst with random backpressure; stray start ignored
      start(0, 16);
      for (int k = 0; k < 6; k++) begin
         rif.I_rready = 1'($urandom_range(0, 1));
         rd_start = (k == 4); rd_base = 7; rd_len = 3;
         nx();
      end
      rd_start = 1'b0;
      wait_done("t4_done", 1);

      // continuous writes racing a burst
      wvalid = 1'b1;
      start(0, 12);
      for (int k = 0; k < 40 && !done; k++) begin
         wdata = 32'hC00 + 32'(k);
         rif.I_rready = 1'($urandom_range(0, 1));
         nx();
      end
      wvalid = 1'b0;
      wait_done("t5_done", 1);

      // zero-length burst
      start(5, 0);
      @(negedge clk); chk("t6_done", done, 1); chk("t6_ce", ce, 0); nx();
      @(negedge clk); chk("t6_done_off", done, 0); nx();

      // reset in the middle of a burst, then a clean burst
      rif.I_rready = 1'b0;
      start(4, 8);
      repeat (4) nx();
      rst = 1'b1; nx(); rst = 1'b0;
      @(negedge clk);
      chk("t7_after", {busy, done, ce, rif.O_rvalid, wcnt}, 0);
      nx();
      rif.I_rready = 1'b1;
      start(3, 3);
      wait_done("t7_done", 0);

      // clear coinciding with a write
      wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wdata = 32'hD0 + 32'(i); nx();
      end
      wclr = 1'b1; wdata = 32'hDD;
      @(negedge clk); chk("t8_addr", addr, 0); chk("t8_wr", wr, 1); nx();
      wclr = 1'b0; wvalid = 1'b0;
      @(negedge clk); chk("t8_wcnt", wcnt, 1); nx();
      start(0, 1);
      wait_done("t8_done", 0);

      repeat (2) nx();
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end
endmodule

// File: doc/ibuf_access_ctrl.md
# ibuf_access_ctrl

Single-port access controller placed directly in front of the `spram` input buffer in the cnna datapath. It accepts a write stream from the DDR/AXI fetch side and packs it into consecutive RAM addresses. It also serves burst read commands from the main process. Reads and writes are time-multiplexed onto the one RAM port. Read data is returned through a 4-entry output FIFO with valid/ready backpressure.

## Interface
- ASIZE, 10, RAM address width; DEPTH = 2^ASIZE.
- DSIZE, 32, data width.
- I_clk  in  1  clock; reset I_rst, synchronous, active-high; clock I_clk.
- I_rst  in  1  synchronous active-high reset.
- I_wclr  in  1  pulse; clears write pointer and write count (frame start).
- I_wdata  in  DSIZE  write stream data.
- I_wvalid  in  1  write data valid.
- O_wready  out  1  write accepted when I_wvalid & O_wready.
- O_wcnt  out  ASIZE+1  words written since clear, saturates at DEPTH.
- I_rd_start  in  1  pulse; starts a burst read.
- I_rd_base  in  ASIZE  first read address.
- I_rd_len  in  ASIZE+1  burst length, 0..DEPTH.
- O_rd_busy  out  1  burst in progress.
- O_rd_done  out  1  one-cycle pulse at burst completion.
- O_rdata  out  DSIZE  read data (FIFO head).
- O_rvalid  out  1  read data valid.
- O_rlast  out  1  marks final beat of the burst.
- I_rready  in  1  downstream ready.
- O_ram_addr / O_ram_data  out  ASIZE / DSIZE  to spram I_addr / I_data.
- O_ram_ce / O_ram_wr  out  1 / 1  to spram I_ce / I_wr.
- I_ram_data  in  DSIZE  from spram O_data (registered, 1-cycle latency).

## Operation
- FSM states: IDLE, RD, DRAIN, DONE.
  - IDLE -> RD on I_rd_start with I_rd_len != 0; base and len are latched.
  - IDLE -> DONE on I_rd_start with I_rd_len == 0; no RAM access.
  - RD -> DRAIN when the last address is issued.
  - DRAIN -> DONE when the FIFO is empty, inflight is 0, and the last beat has been handshaken.
  - DONE -> IDLE unconditionally.
  - O_rd_busy = (RD | DRAIN); O_rd_done = (DONE).
  - I_rd_start outside IDLE is ignored.
- Read issue:
  - rd_issue = (state == RD) & (fifo_cnt + inflight < 4). Both terms are registered, so rd_issue has no combinational path from I_rready.
  - On rd_issue: O_ram_ce = 1, O_ram_wr = 0, O_ram_addr = (base + idx) mod DEPTH, so the address wraps DEPTH-1 -> 0.
  - inflight is set for one cycle. The following cycle, I_ram_data is pushed into the FIFO, tagged last if idx was len-1.
- Write path:
  - O_wready = ~I_rst & ~rd_issue. Read has strict priority.
  - On write accept: O_ram_ce = 1, O_ram_wr = 1, O_ram_addr = wptr, O_ram_data = I_wdata.
  - wptr increments and wraps DEPTH-1 -> 0. wcnt increments, saturating at DEPTH.
- I_wclr:
  - With no accept in the same cycle: wptr = 0 and wcnt = 0.
  - With an accept in the same cycle: the write goes to address 0, then wptr = 1 and wcnt = 1.
- Idle port: O_ram_ce = 0, O_ram_wr = 0.
- FIFO: 4 entries.
  - Pop on O_rvalid & I_rready. Simultaneous push and pop is allowed.
  - Overflow cannot occur, because of the credit rule.
- Reset (any time, including mid-burst):
  - FSM -> IDLE; wptr, wcnt, idx, inflight and fifo_cnt -> 0; FIFO is flushed.
  - All outputs are 0, including O_wready, O_rvalid, O_rd_busy, O_rd_done, O_ram_ce and O_ram_wr.
  - O_rdata and O_ram_addr are 0 during reset.

## Timing
- Latency: I_rd_start sampled at edge E0.
  - First issue in the cycle after E0.
  - I_ram_data valid after E1; pushed at E2; O_rvalid high after E2, i.e. 3 edges after start.
- Throughput: 1 read/cycle sustained when I_rready = 1.
- Write stall: the write stream stalls only in cycles where rd_issue = 1.
- O_rd_done: asserted the cycle after the last-beat handshake, for exactly 1 cycle.
- O_wcnt: updates the cycle after the accept.

## Test plan
- Write 8 words 0xA0..0xA7 after I_wclr, no reads. Required: addresses 0..7 with O_ram_wr = 1, O_wcnt = 8, O_wready always 1.
- Burst base = 2, len = 4, I_rready = 1 after the write test. Required: O_rvalid 3 edges after start; data 0xA2..0xA5; O_rlast on 0xA5; O_rd_done 1 cycle later; busy deasserts.
- ASIZE = 4, base = 14, len = 4. Required: O_ram_addr 14, 15, 0, 1. Also write 17 words: wptr wraps to 1 and O_wcnt saturates at 16.
- Burst len = 16 with I_rready toggled 1/0 randomly. Required: no data lost or duplicated; inflight + fifo_cnt ≤ 4; O_rvalid held while I_rready = 0.
- Continuous I_wvalid during a burst. Required: O_wready = 0 exactly in issue cycles; all writes land in order; reads return pre-write or post-write data consistent with the accept order.
- len = 0 gives O_rd_done after 1 cycle with no RAM access. I_rst mid-burst gives all outputs 0 next cycle, and a new burst then runs correctly. I_wclr with a simultaneous write gives the write at address 0 and O_wcnt = 1.
